// File: rtl/paged_mem_pkg.sv
// Shared types for the paged RAM: swap-controller states, page-table entry
// layout and helpers deriving tag/offset widths from the address parameters.
package paged_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        WB_RD,
        WB_REQ,
        FILL_REQ,
        FILL_WR,
        COMMIT
    } state_e;

    // Entry tags are stored zero-extended to this width; the live tag width is TW.
    localparam int PT_TAG_MAX = 32;

    typedef struct packed {
        logic [PT_TAG_MAX-1:0] tag;
        logic                  valid;
        logic                  dirty;
    } pt_entry_t;

    function automatic int tag_width(input int widthad, input int hwwidthad, input int divsize);
        return widthad - (hwwidthad - divsize);
    endfunction

    function automatic int off_width(input int hwwidthad, input int divsize);
        return hwwidthad - divsize;
    endfunction

endpackage

// File: rtl/page_swap_controller_victim.sv
// Slot selection for a page miss: resident-tag hit, else lowest invalid slot,
// else the round-robin slot (which also advances the pointer).
module victim_select
    import paged_mem_pkg::*;
#(
    parameter int divsize = 4
) (
    input  logic [(1<<divsize)-1:0] valid_i,
    input  logic [(1<<divsize)-1:0] match_i,
    input  logic [divsize-1:0]      rr_i,
    output logic                    hit_o,
    output logic [divsize-1:0]      victim_o,
    output logic [divsize-1:0]      rr_next_o
);

    localparam int PAGES = 1 << divsize;

    logic               free;
    logic [divsize-1:0] hit_idx;
    logic [divsize-1:0] free_idx;

    always_comb begin
        hit_o     = 1'b0;
        free      = 1'b0;
        hit_idx   = '0;
        free_idx  = '0;
        victim_o  = rr_i;
        rr_next_o = rr_i;
        // Scan downwards so the lowest matching / free index wins.
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (valid_i[i] && match_i[i]) begin
                hit_o   = 1'b1;
                hit_idx = divsize'(i);
            end
            if (!valid_i[i]) begin
                free     = 1'b1;
                free_idx = divsize'(i);
            end
        end
        if (hit_o) begin
            victim_o = hit_idx;
        end else if (free) begin
            victim_o = free_idx;
        end else begin
            rr_next_o = rr_i + 1'b1;
        end
    end

endmodule

// File: rtl/page_swap_controller.sv
// Installs a missing page: pick a slot, write back a dirty victim, fill from
// backing store, then publish the new page-table entry.
//   state    | meaning
//   IDLE     | waiting for a miss; accepts dirty marks
//   PICK     | hit check / victim choice
//   WB_RD    | read victim word from page RAM
//   WB_REQ   | write victim word to backing store
//   FILL_REQ | read new word from backing store
//   FILL_WR  | write new word into page RAM
//   COMMIT   | update page table, pulse miss_ready
module page_swap_controller
    import paged_mem_pkg::*;
#(
    parameter int widthad   = 32,
    parameter int hwwidthad = 16,
    parameter int width     = 32,
    parameter int divsize   = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         miss_valid,
    input  logic [tag_width(widthad,hwwidthad,divsize)-1:0] miss_tag,
    output logic                                         miss_ready,
    output logic                                         busy,
    input  logic                                         dirty_set,
    input  logic [divsize-1:0]                           dirty_idx,
    output logic                                         pt_we,
    output logic [divsize-1:0]                           pt_idx,
    output logic [tag_width(widthad,hwwidthad,divsize)-1:0] pt_tag,
    output logic                                         pt_valid,
    output logic [hwwidthad-1:0]                         ram_addr,
    output logic                                         ram_rden,
    output logic                                         ram_wren,
    output logic [width-1:0]                             ram_data,
    input  logic [width-1:0]                             ram_q,
    output logic                                         bs_req,
    output logic                                         bs_we,
    output logic [widthad-1:0]                           bs_addr,
    output logic [width-1:0]                             bs_wdata,
    input  logic                                         bs_ack,
    input  logic [width-1:0]                             bs_rdata
);

    localparam int TW    = tag_width(widthad, hwwidthad, divsize);
    localparam int OW    = off_width(hwwidthad, divsize);
    localparam int PAGES = 1 << divsize;
    localparam logic [OW-1:0] LAST_WORD = '1;

    state_e             state_q, state_d;
    pt_entry_t          pt_q [PAGES];
    pt_entry_t          pt_d [PAGES];
    logic [TW-1:0]      tag_q, tag_d;
    logic [TW-1:0]      old_tag_q, old_tag_d;
    logic [divsize-1:0] rr_q, rr_d;
    logic [divsize-1:0] slot_q, slot_d;
    logic [OW-1:0]      wc_q, wc_d;
    logic               wb_first_q, wb_first_d;
    logic [width-1:0]   wb_data_q, wb_data_d;
    logic [width-1:0]   ram_data_q, ram_data_d;

    logic               miss_ready_q, miss_ready_d;
    logic               busy_q, busy_d;
    logic               pt_we_q, pt_we_d;
    logic [divsize-1:0] pt_idx_q, pt_idx_d;
    logic [TW-1:0]      pt_tag_q, pt_tag_d;
    logic               pt_valid_q, pt_valid_d;
    logic [hwwidthad-1:0] ram_addr_q, ram_addr_d;
    logic               ram_rden_q, ram_rden_d;
    logic               ram_wren_q, ram_wren_d;
    logic               bs_req_q, bs_req_d;
    logic               bs_we_q, bs_we_d;
    logic [widthad-1:0] bs_addr_q, bs_addr_d;

    logic [PAGES-1:0]   valid_vec;
    logic [PAGES-1:0]   match_vec;
    logic               vs_hit;
    logic [divsize-1:0] vs_victim;
    logic [divsize-1:0] vs_rr_next;

    always_comb begin
        valid_vec = '0;
        match_vec = '0;
        for (int i = 0; i < PAGES; i++) begin
            valid_vec[i] = pt_q[i].valid;
            match_vec[i] = (pt_q[i].tag == PT_TAG_MAX'(tag_q));
        end
    end

    victim_select #(.divsize(divsize)) u_victim (
        .valid_i   (valid_vec),
        .match_i   (match_vec),
        .rr_i      (rr_q),
        .hit_o     (vs_hit),
        .victim_o  (vs_victim),
        .rr_next_o (vs_rr_next)
    );

    always_comb begin
        state_d    = state_q;
        pt_d       = pt_q;
        tag_d      = tag_q;
        old_tag_d  = old_tag_q;
        rr_d       = rr_q;
        slot_d     = slot_q;
        wc_d       = wc_q;
        wb_first_d = 1'b0;
        wb_data_d  = wb_data_q;
        ram_data_d = ram_data_q;

        case (state_q)
            IDLE: begin
                if (dirty_set) pt_d[dirty_idx].dirty = 1'b1;
                if (miss_valid) begin
                    tag_d   = miss_tag;
                    state_d = PICK;
                end
            end
            PICK: begin
                slot_d    = vs_victim;
                wc_d      = '0;
                old_tag_d = TW'(pt_q[vs_victim].tag);
                if (vs_hit) begin
                    state_d = COMMIT;
                end else begin
                    rr_d    = vs_rr_next;
                    state_d = (pt_q[vs_victim].valid && pt_q[vs_victim].dirty) ? WB_RD : FILL_REQ;
                end
            end
            WB_RD: begin
                wb_first_d = 1'b1;
                state_d    = WB_REQ;
            end
            WB_REQ: begin
                if (wb_first_q) wb_data_d = ram_q;
                if (bs_ack) begin
                    wc_d    = wc_q + 1'b1;
                    state_d = (wc_q == LAST_WORD) ? FILL_REQ : WB_RD;
                end
            end
            FILL_REQ: begin
                if (bs_ack) begin
                    ram_data_d = bs_rdata;
                    state_d    = FILL_WR;
                end
            end
            FILL_WR: begin
                wc_d    = wc_q + 1'b1;
                state_d = (wc_q == LAST_WORD) ? COMMIT : FILL_REQ;
            end
            COMMIT: begin
                pt_d[slot_q].tag   = PT_TAG_MAX'(tag_q);
                pt_d[slot_q].valid = 1'b1;
                pt_d[slot_q].dirty = 1'b0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output registers are loaded from the upcoming state so strobes line up with it.
        busy_d       = (state_d != IDLE);
        miss_ready_d = (state_d == COMMIT);
        pt_we_d      = (state_d == COMMIT);
        pt_idx_d     = (state_d == COMMIT) ? slot_d : '0;
        pt_tag_d     = (state_d == COMMIT) ? tag_d : '0;
        pt_valid_d   = (state_d == COMMIT);
        ram_rden_d   = (state_d == WB_RD);
        ram_wren_d   = (state_d == FILL_WR);
        ram_addr_d   = (state_d == WB_RD || state_d == FILL_WR) ? {slot_d, wc_d} : '0;
        bs_req_d     = (state_d == WB_REQ || state_d == FILL_REQ);
        bs_we_d      = (state_d == WB_REQ);
        bs_addr_d    = (state_d == WB_REQ)   ? {old_tag_d, wc_d} :
                       (state_d == FILL_REQ) ? {tag_d, wc_d} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < PAGES; i++) pt_q[i] <= '0;
            tag_q        <= '0;
            old_tag_q    <= '0;
            rr_q         <= '0;
            slot_q       <= '0;
            wc_q         <= '0;
            wb_first_q   <= 1'b0;
            wb_data_q    <= '0;
            ram_data_q   <= '0;
            miss_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            pt_we_q      <= 1'b0;
            pt_idx_q     <= '0;
            pt_tag_q     <= '0;
            pt_valid_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            bs_req_q     <= 1'b0;
            bs_we_q      <= 1'b0;
            bs_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            pt_q         <= pt_d;
            tag_q        <= tag_d;
            old_tag_q    <= old_tag_d;
            rr_q         <= rr_d;
            slot_q       <= slot_d;
            wc_q         <= wc_d;
            wb_first_q   <= wb_first_d;
            wb_data_q    <= wb_data_d;
            ram_data_q   <= ram_data_d;
            miss_ready_q <= miss_ready_d;
            busy_q       <= busy_d;
            pt_we_q      <= pt_we_d;
            pt_idx_q     <= pt_idx_d;
            pt_tag_q     <= pt_tag_d;
            pt_valid_q   <= pt_valid_d;
            ram_addr_q   <= ram_addr_d;
            ram_rden_q   <= ram_rden_d;
            ram_wren_q   <= ram_wren_d;
            bs_req_q     <= bs_req_d;
            bs_we_q      <= bs_we_d;
            bs_addr_q    <= bs_addr_d;
        end
    end

    assign miss_ready = miss_ready_q;
    assign busy       = busy_q;
    assign pt_we      = pt_we_q;
    assign pt_idx     = pt_idx_q;
    assign pt_tag     = pt_tag_q;
    assign pt_valid   = pt_valid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rden   = ram_rden_q;
    assign ram_wren   = ram_wren_q;
    assign ram_data   = ram_data_q;
    assign bs_req     = bs_req_q;
    assign bs_we      = bs_we_q;
    assign bs_addr    = bs_addr_q;
    // RAM read data arrives in the first WB_REQ cycle; later wait cycles use the held copy.
    assign bs_wdata   = wb_first_q ? ram_q : wb_data_q;

endmodule

// File: tb/tb_page_swap_controller.sv
// Directed bench for page_swap_controller: RAM and backing-store models with a
// scoreboard of expected bus, RAM and page-table traffic.
module tb_page_swap_controller;

    localparam int WA = 8, HW = 6, DS = 2, DW = 8, WORDS = 16;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } xact_t;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] tag;
    } pt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic miss_valid = 1'b0;
    logic [3:0] miss_tag = '0;
    logic miss_ready, busy;
    logic dirty_set = 1'b0;
    logic [1:0] dirty_idx = '0;
    logic pt_we, pt_valid;
    logic [1:0] pt_idx;
    logic [3:0] pt_tag;
    logic [5:0] ram_addr;
    logic ram_rden, ram_wren;
    logic [7:0] ram_data;
    logic [7:0] ram_q = '0;
    logic bs_req, bs_we;
    logic [7:0] bs_addr, bs_wdata;
    logic bs_ack = 1'b0;
    logic [7:0] bs_rdata = '0;

    int checks = 0;
    int failures = 0;

    xact_t bs_exp[$];
    xact_t ram_exp[$];
    pt_t   pt_exp[$];

    logic [7:0] ram_mem [64];
    logic       tb_wr_en = 1'b0;
    logic [5:0] tb_wr_addr = '0;
    logic [7:0] tb_wr_data = '0;
    logic [7:0] bs_mem [256];
    bit         bs_wr_valid [256];
    int         bs_delay = 0;
    int         wcnt = 0;

    bit         exp_valid [4];
    bit         exp_dirty [4];
    logic [3:0] exp_tag [4];
    int         exp_rr = 0;
    logic [7:0] exp_ram [64];

    always #5 clk = ~clk;

    page_swap_controller #(.widthad(WA), .hwwidthad(HW), .width(DW), .divsize(DS)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_tag(miss_tag), .miss_ready(miss_ready), .busy(busy),
        .dirty_set(dirty_set), .dirty_idx(dirty_idx),
        .pt_we(pt_we), .pt_idx(pt_idx), .pt_tag(pt_tag), .pt_valid(pt_valid),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
        .bs_req(bs_req), .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
        .bs_ack(bs_ack), .bs_rdata(bs_rdata)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] bs_read(input logic [7:0] a);
        return bs_wr_valid[a] ? bs_mem[a] : ({a[3:0], a[7:4]} ^ 8'hA5);
    endfunction

    // Page RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_rden) ram_q <= ram_mem[ram_addr];
        if (ram_wren) ram_mem[ram_addr] <= ram_data;
        if (tb_wr_en) ram_mem[tb_wr_addr] <= tb_wr_data;
    end

    // Backing store: ack after bs_delay wait cycles; every req cycle is checked against the head.
    always @(negedge clk) begin
        xact_t e;
        bs_ack = 1'b0;
        if (!rst_n || !bs_req) begin
            wcnt = 0;
        end else begin
            if (bs_exp.size() > 0) e = bs_exp[0];
            else e = '{we: 1'bx, addr: 8'hxx, data: 8'hxx};
            chk("bs_we", {31'b0, bs_we}, {31'b0, e.we});
            chk("bs_addr", {24'b0, bs_addr}, {24'b0, e.addr});
            if (e.we === 1'b1) chk("bs_wdata", {24'b0, bs_wdata}, {24'b0, e.data});
            if (wcnt == bs_delay) begin
                bs_ack = 1'b1;
                wcnt = 0;
                if (bs_exp.size() > 0) void'(bs_exp.pop_front());
                if (bs_we) begin
                    bs_mem[bs_addr] = bs_wdata;
                    bs_wr_valid[bs_addr] = 1'b1;
                end else begin
                    bs_rdata = bs_read(bs_addr);
                end
            end else begin
                wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        xact_t e;
        if (rst_n && ram_wren) begin
            if (ram_exp.size() > 0) e = ram_exp.pop_front();
            else e = '{we: 1'bx, addr: 8'hxx, data: 8'hxx};
            chk("ram_waddr", {26'b0, ram_addr}, {24'b0, e.addr});
            chk("ram_wdata", {24'b0, ram_data}, {24'b0, e.data});
        end
    end

    always @(negedge clk) begin
        pt_t p;
        if (rst_n && pt_we) begin
            if (pt_exp.size() > 0) p = pt_exp.pop_front();
            else p = '{idx: 2'bxx, tag: 4'hx};
            chk("pt_idx", {30'b0, pt_idx}, {30'b0, p.idx});
            chk("pt_tag", {28'b0, pt_tag}, {28'b0, p.tag});
            chk("pt_valid", {31'b0, pt_valid}, 32'd1);
        end
    end

    // Works out the victim from the bench's own slot model and queues the expected traffic.
    task automatic plan_miss(input logic [3:0] tag, output int v, output bit hit, output bit wb);
        logic [3:0] wl;
        logic [1:0] vl;
        logic [7:0] d;
        hit = 1'b0;
        v = -1;
        for (int i = 0; i < 4; i++)
            if (!hit && exp_valid[i] && exp_tag[i] == tag) begin hit = 1'b1; v = i; end
        if (!hit) begin
            for (int i = 3; i >= 0; i--) if (!exp_valid[i]) v = i;
            if (v < 0) begin v = exp_rr; exp_rr = (exp_rr + 1) % 4; end
        end
        vl = 2'(v);
        wb = !hit && exp_valid[v] && exp_dirty[v];
        if (wb)
            for (int w = 0; w < WORDS; w++) begin
                wl = 4'(w);
                bs_exp.push_back('{we: 1'b1, addr: {exp_tag[v], wl}, data: exp_ram[{vl, wl}]});
            end
        if (!hit)
            for (int w = 0; w < WORDS; w++) begin
                wl = 4'(w);
                d = bs_read({tag, wl});
                bs_exp.push_back('{we: 1'b0, addr: {tag, wl}, data: 8'h00});
                ram_exp.push_back('{we: 1'b1, addr: {2'b00, vl, wl}, data: d});
                exp_ram[{vl, wl}] = d;
            end
    endtask

    task automatic do_miss(input logic [3:0] tag, input int delay, input bit inject_dirty);
        int v, cyc, exp_lat;
        bit hit, wb;
        plan_miss(tag, v, hit, wb);
        pt_exp.push_back('{idx: 2'(v), tag: tag});
        exp_lat = hit ? 2 : 2 + WORDS * (2 + delay) * (wb ? 2 : 1);
        bs_delay = delay;
        dirty_idx = 2'd2;
        miss_tag = tag;
        miss_valid = 1'b1;
        cyc = 0;
        while (!miss_ready && cyc < 400) begin
            @(negedge clk);
            cyc++;
            dirty_set = inject_dirty && (cyc == 10);
        end
        miss_valid = 1'b0;
        dirty_set = 1'b0;
        chk("miss_latency", cyc, exp_lat);
        exp_valid[v] = 1'b1;
        exp_tag[v] = tag;
        exp_dirty[v] = 1'b0;
        @(negedge clk);
        chk("bs_queue_drained", bs_exp.size(), 0);
        chk("ram_queue_drained", ram_exp.size(), 0);
        chk("pt_queue_drained", pt_exp.size(), 0);
        chk("idle_after_commit", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int v, cyc;
        bit hit, wb;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_miss_ready", {31'b0, miss_ready}, 32'd0);
        chk("rst_bs_req", {31'b0, bs_req}, 32'd0);
        chk("rst_pt_we", {31'b0, pt_we}, 32'd0);
        chk("rst_ram_strobes", {30'b0, ram_rden, ram_wren}, 32'd0);
        chk("rst_addrs", {18'b0, ram_addr, bs_addr}, 32'd0);
        chk("rst_bs_wdata", {24'b0, bs_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_miss(4'h3, 0, 1'b0);            // cold miss into slot 0
        do_miss(4'h3, 0, 1'b0);            // resident: no transfer
        do_miss(4'h5, 0, 1'b0);
        do_miss(4'h6, 0, 1'b0);
        do_miss(4'h7, 0, 1'b0);

        // Write hits into slot 0, then mark it dirty.
        for (int w = 0; w < WORDS; w++) begin
            tb_wr_en = 1'b1;
            tb_wr_addr = 6'(w);
            tb_wr_data = 8'hE0 ^ 8'(w * 7);
            exp_ram[w] = tb_wr_data;
            @(negedge clk);
        end
        tb_wr_en = 1'b0;
        dirty_idx = 2'd0;
        dirty_set = 1'b1;
        @(negedge clk);
        dirty_set = 1'b0;
        exp_dirty[0] = 1'b1;
        @(negedge clk);

        do_miss(4'h9, 0, 1'b0);            // dirty eviction of slot 0, rr -> 1
        do_miss(4'hA, 3, 1'b1);            // slow store; dirty_set while busy is dropped
        do_miss(4'hB, 0, 1'b0);            // slot 2 must still be clean

        // Reset in the middle of the fill for word 5.
        plan_miss(4'hC, v, hit, wb);
        bs_delay = 0;
        miss_tag = 4'hC;
        miss_valid = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(bs_req && !bs_we && bs_addr == 8'hC5) && cyc < 200);
        chk("abort_point_addr", {24'b0, bs_addr}, 32'h0000_00C5);
        rst_n = 1'b0;
        #1;
        chk("abort_bs_req", {31'b0, bs_req}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ram_wren", {31'b0, ram_wren}, 32'd0);
        miss_valid = 1'b0;
        repeat (2) @(negedge clk);
        bs_exp.delete();
        ram_exp.delete();
        pt_exp.delete();
        for (int i = 0; i < 4; i++) begin exp_valid[i] = 1'b0; exp_dirty[i] = 1'b0; end
        exp_rr = 0;
        rst_n = 1'b1;
        @(negedge clk);

        do_miss(4'hC, 0, 1'b0);            // full refill into slot 0

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
